// File: rtl/nn_weight_dump.sv
// Snapshots the three neurons' weights on start and streams them as a framed byte
// sequence over valid/ready: HEADER, ten weight bytes, then an 8-bit additive checksum.
module nn_weight_dump #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] hn0_weights_i,
  input  logic [31:0] hn1_weights_i,
  input  logic [15:0] on_weights_i,
  input  logic        ready_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHECKSUM,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [3:0]  idx_reg;
  logic [79:0] snap_reg;
  logic [7:0]  chk_reg;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [79:0] live_weights;
  logic [7:0]  live_bytes [10];
  logic [7:0]  snap_bytes [10];
  logic [7:0]  live_sum;
  logic [3:0]  next_idx;
  logic [7:0]  next_byte;
  logic        xfer;

  // Byte k of the frame payload is bits [8k+7:8k] of {on, hn1, hn0}.
  assign live_weights = {on_weights_i, hn1_weights_i, hn0_weights_i};

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_bytes
      assign live_bytes[gi] = live_weights[gi*8 +: 8];
      assign snap_bytes[gi] = snap_reg[gi*8 +: 8];
    end
  endgenerate

  // Checksum is taken from the same values that enter the snapshot, so it is fixed for the frame.
  always_comb begin
    live_sum = 8'h00;
    for (int i = 0; i < 10; i++) begin
      live_sum = live_sum + live_bytes[i];
    end
  end

  assign next_idx = idx_reg + 4'd1;

  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (next_idx == i[3:0]) begin
        next_byte = snap_bytes[i];
      end
    end
  end

  assign xfer = valid_reg & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      idx_reg   <= 4'd0;
      snap_reg  <= 80'd0;
      chk_reg   <= 8'h00;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start_i) begin
            snap_reg  <= live_weights;
            chk_reg   <= live_sum;
            idx_reg   <= 4'd0;
            data_reg  <= HEADER;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            idx_reg   <= 4'd0;
            data_reg  <= snap_bytes[0];
            state_reg <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            if (idx_reg == 4'd9) begin
              data_reg  <= chk_reg;
              state_reg <= S_CHECKSUM;
            end else begin
              idx_reg  <= next_idx;
              data_reg <= next_byte;
            end
          end
        end
        S_CHECKSUM: begin
          if (xfer) begin
            data_reg  <= 8'h00;
            valid_reg <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          idx_reg   <= 4'd0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: doc/nn_weight_dump.md
# nn_weight_dump

Read-side companion to the training datapath. On a start pulse it snapshots the current weights (hidden neuron 0, hidden neuron 1 and output neuron) and streams them out as a framed byte sequence over a valid/ready interface. The host or pin multiplexer can then read back what backprop wrote. It sits beside the state machine and backprop units and only reads their weight buses.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle request to begin a dump; ignored while busy_o=1.
- hn0_weights_i  in  32  hidden neuron 0 weights; w0=[7:0], w1=[15:8], w2=[23:16], w3=[31:24].
- hn1_weights_i  in  32  hidden neuron 1 weights, same packing.
- on_weights_i  in  16  output neuron weights; w0=[7:0], w1=[15:8].
- ready_i  in  1  consumer accepts data_o this cycle.
- data_o  out  8  current frame byte.
- valid_o  out  1  data_o is valid.
- busy_o  out  1  a frame is in progress.
- done_o  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation
- Frame, 12 bytes, in this order:
  - HEADER;
  - hn0 w0, w1, w2, w3;
  - hn1 w0, w1, w2, w3;
  - on w0, w1;
  - CHK = sum of the 10 weight bytes, mod 256. HEADER is not included in CHK.
- Snapshot: on an accepted start, all 80 weight bits are registered into an internal copy. Input weight changes during the frame have no effect on it.
- States:
  - IDLE: on start_i -> HEADER.
  - HEADER: on transfer -> PAYLOAD, idx=0.
  - PAYLOAD: on each transfer idx++. Transfer at idx=9 -> CHECKSUM.
  - CHECKSUM: on transfer -> DONE.
  - DONE: one cycle, done_o=1, then -> IDLE.
- Transfer = valid_o & ready_i on a rising edge.
- data_o selects from state and idx through a 4-bit index mux over the snapshot. idx never exceeds 9.
- CHK is accumulated from the snapshot, either at capture or per byte; both are allowed. It must equal the defined sum whatever the ready_i pattern.
- valid_o=1 in HEADER, PAYLOAD and CHECKSUM only.
- busy_o=1 in every state except IDLE.
- start_i is ignored in every non-IDLE state, including DONE.

## Timing
- Reset values: data_o=0, valid_o=0, busy_o=0, done_o=0, state IDLE, idx=0, snapshot=0, CHK accumulator=0.
- start_i sampled high at edge t -> valid_o=1, data_o=HEADER, busy_o=1 from t+1.
- Backpressure: while valid_o=1 and ready_i=0, data_o, valid_o and state hold stable.
- Each transfer advances exactly one byte. The next byte is presented in the following cycle.
- Minimum frame time with ready_i held at 1:
  - 12 cycles of valid_o;
  - done_o in cycle 13 after start;
  - busy_o falls at cycle 14, and a new start is accepted there.
- ready_i=1 while valid_o=0 has no effect.
- start_i and ready_i high together in IDLE: start is taken, and no transfer occurs that cycle.
- rst_i mid-frame: all outputs return to reset values at the next edge. The frame is abandoned and done_o is not pulsed. rst_i overrides start_i.

## Test plan
- Basic frame: hn0=32'h04030201, hn1=32'h04030201, on=16'h0201, ready_i=1, pulse start -> bytes A5 01 02 03 04 01 02 03 04 01 02 17 on 12 consecutive cycles, done_o in cycle 13.
- Checksum wrap: all weight bytes 8'hFF -> 10 bytes of FF, then CHK=8'hF6.
- Backpressure: ready_i toggles 1,0,0,1 repeating -> same 12-byte sequence, data_o stable through every ready_i=0 cycle, CHK unchanged.
- Snapshot isolation: change hn0_weights_i to 32'hDEADBEEF right after start -> the frame still carries the original values.
- Start while busy: pulse start_i at byte 5 -> ignored, exactly one frame and one done_o.
- Reset mid-frame: assert rst_i during PAYLOAD idx=3 -> valid_o=0 and busy_o=0 next cycle, no done_o; a following start produces a complete fresh frame starting with A5.
